rst_gen: RTL

//  Reset sequencer directly downstream of the MMCM clock generator. Runs on the generated clock.

---
 rtl/rst_gen_pkg.sv | 35 +++
 rtl/rst_gen_sync.sv | 26 ++
 rtl/rst_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rst_gen_pkg.sv
// Shared definitions for the reset sequencer: state encodings, status width,
// and small elaboration-time helpers.
package rst_gen_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_STAGGER   = 3'd3,
    ST_RUN       = 3'd4
  } rst_state_e;

  localparam int unsigned          LOCK_CNT_W   = 8;
  localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_MAX = '1;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while (result < 32 && (64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that can hold 0..max_count-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (clog2(max_count) > 0) ? clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/rst_gen_sync.sv
// Multi-flop synchroniser with asynchronous active-low clear. Used both to
// synchronise reset deassertion (d_i tied high) and to bring MMCM lock into the clock domain.
module rst_sync #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: non-blocking assignments make every stage sample the previous stage's
  // old value, which is what turns this into a shift chain rather than a wire.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_gen.sv
// Reset sequencer behind the MMCM: waits for a stable lock, holds reset, then
// releases the domains one at a time and pulls them all back on lock loss.
module rst_gen
  import rst_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 3,
  parameter int unsigned LOCK_STABLE_CYC = 1024,
  parameter int unsigned RST_HOLD_CYC    = 16,
  parameter int unsigned STAGGER_CYC     = 4,
  parameter int unsigned NUM_RST         = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mmcm_locked,
  output logic [NUM_RST-1:0]    o_rst_n,
  output logic                  o_ready,
  output logic [LOCK_CNT_W-1:0] o_lock_lost_cnt
);

  localparam int unsigned MAX_CYC = max2(max2(LOCK_STABLE_CYC, RST_HOLD_CYC), STAGGER_CYC);
  localparam int unsigned CNT_W   = cnt_width(MAX_CYC);
  localparam int unsigned IDX_W   = cnt_width(NUM_RST);

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
  localparam logic [LOCK_CNT_W-1:0] LOST_ONE = LOCK_CNT_W'(1);

  logic rst_s_n;
  logic locked_s;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .d_i     (1'b1),
    .q_o     (rst_s_n)
  );

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i   (i_clk),
    .rst_n_i (rst_s_n),
    .d_i     (i_mmcm_locked),
    .q_o     (locked_s)
  );

  rst_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_RST-1:0]      rst_n_q, rst_n_d;
  logic                    ready_q, ready_d;
  logic [LOCK_CNT_W-1:0]   lost_q, lost_d;

  always_ff @(posedge i_clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no branch can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    lost_d  = lost_q;

    if (state_q != ST_WAIT_LOCK && !locked_s) begin
      // Lock loss overrides every counter condition, including a due release.
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
      if ((state_q == ST_STAGGER || state_q == ST_RUN) && lost_q != LOCK_CNT_MAX) begin
        lost_d = lost_q + LOST_ONE;
      end
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end
        end
        ST_STABLE: begin
          if (cnt_q == STABLE_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_n_d[0] = 1'b1;
            cnt_d      = '0;
            idx_d      = '0;
            if (NUM_RST == 1) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_STAGGER;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STAGGER: begin
          if (cnt_q == STAGGER_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_ONE;
            for (int i = 1; i < NUM_RST; i++) begin
              if (i == int'(idx_q) + 1) begin
                rst_n_d[i] = 1'b1;
              end
            end
            if (int'(idx_q) + 2 == NUM_RST) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  assign o_rst_n         = rst_n_q;
  assign o_ready         = ready_q;
  assign o_lock_lost_cnt = lost_q;

endmodule
